// File: rtl/wb_stream_writer_ctrl.sv
// wb_stream_writer_ctrl: Wishbone burst-read master feeding the stream writer FIFO.
// A burst is only issued once the FIFO has room for every beat of it.
module wb_stream_writer_ctrl #(
    parameter int WB_AW     = 32,
    parameter int WB_DW     = 32,
    parameter int FIFO_AW   = 9,
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_i,
    input  logic [WB_AW-1:0]     start_adr_i,
    input  logic [LEN_W-1:0]     buf_size_i,
    input  logic [7:0]           burst_size_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [WB_AW-1:0]     wbm_adr_o,
    output logic [WB_DW/8-1:0]   wbm_sel_o,
    output logic                 wbm_we_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic [2:0]           wbm_cti_o,
    output logic [1:0]           wbm_bte_o,
    input  logic [WB_DW-1:0]     wbm_dat_i,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i,
    input  logic [FIFO_AW:0]     fifo_cnt_i,
    output logic [WB_DW-1:0]     fifo_data_o,
    output logic                 fifo_valid_o,
    input  logic                 fifo_ready_i
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int CW = FIFO_AW + 2;
    localparam logic [WB_AW-1:0] STEP   = WB_AW'(WB_DW / 8);
    localparam logic [CW-1:0]    DEPTH  = CW'(2 ** FIFO_AW);
    localparam logic [BW-1:0]    MAX_BW = BW'(MAX_BURST);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic             enable_q;
    logic [WB_AW-1:0] adr;
    logic [LEN_W-1:0] rem;
    logic [BW-1:0]    blen_cfg;
    logic [BW-1:0]    beats;
    logic [BW-1:0]    blen_in;
    logic [BW-1:0]    len;
    logic             cyc;
    logic             busy;
    logic             done;
    logic             err;
    logic             start;
    logic             room;
    logic             last_beat;

    assign start     = enable_i & ~enable_q;
    assign last_beat = (beats == BW'(1));

    always_comb begin
        blen_in = MAX_BW;
        if (burst_size_i == 8'd0)
            blen_in = BW'(1);
        else if (32'(burst_size_i) <= 32'(MAX_BURST))
            blen_in = BW'(burst_size_i);
    end

    // Next burst is the configured length, trimmed to what is left.
    always_comb begin
        len = blen_cfg;
        if (rem < LEN_W'(blen_cfg))
            len = BW'(rem);
    end

    assign room = ({1'b0, fifo_cnt_i} + CW'(len)) <= DEPTH;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            enable_q <= 1'b0;
            adr      <= '0;
            rem      <= '0;
            blen_cfg <= '0;
            beats    <= '0;
            cyc      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            enable_q <= enable_i;
            done     <= 1'b0;
            // An accepted beat the FIFO could not take means the space check was broken.
            if (cyc && wbm_ack_i && !wbm_err_i && !fifo_ready_i)
                err <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        adr      <= start_adr_i;
                        rem      <= buf_size_i;
                        blen_cfg <= blen_in;
                        err      <= 1'b0;
                        if (buf_size_i == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (!enable_i) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (room) begin
                        state <= S_BURST;
                        cyc   <= 1'b1;
                        beats <= len;
                    end
                end
                S_BURST: begin
                    if (wbm_err_i) begin
                        cyc   <= 1'b0;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (wbm_ack_i) begin
                        adr   <= adr + STEP;
                        beats <= beats - BW'(1);
                        rem   <= rem - LEN_W'(1);
                        if (last_beat) begin
                            cyc <= 1'b0;
                            if (rem == LEN_W'(1)) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else if (!enable_i) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= S_WAIT;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o       = busy;
    assign done_o       = done;
    assign err_o        = err;
    assign wbm_adr_o    = adr;
    assign wbm_sel_o    = '1;
    assign wbm_we_o     = 1'b0;
    assign wbm_cyc_o    = cyc;
    assign wbm_stb_o    = cyc;
    assign wbm_cti_o    = cyc ? (last_beat ? 3'b111 : 3'b010) : 3'b000;
    assign wbm_bte_o    = 2'b00;
    assign fifo_data_o  = wbm_dat_i;
    assign fifo_valid_o = wbm_ack_i & wbm_cyc_o & wbm_stb_o;

endmodule

// File: tb/tb_wb_stream_writer_ctrl.sv
// tb_wb_stream_writer_ctrl: randomized and directed bench for wb_stream_writer_ctrl
// with a transfer-level reference model and a per-cycle compare process.
module tb_wb_stream_writer_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable_i = 1'b0;
    logic [31:0] start_adr_i = '0;
    logic [23:0] buf_size_i = '0;
    logic [7:0]  burst_size_i = '0;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] wbm_adr_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0;
    logic        wbm_err_i = 1'b0;
    logic [9:0]  fifo_cnt_i = '0;
    logic [31:0] fifo_data_o;
    logic        fifo_valid_o;
    logic        fifo_ready_i = 1'b1;

    wb_stream_writer_ctrl dut (
        .clk(clk), .rst(rst), .enable_i(enable_i),
        .start_adr_i(start_adr_i), .buf_size_i(buf_size_i),
        .burst_size_i(burst_size_i), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .wbm_adr_o(wbm_adr_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .fifo_cnt_i(fifo_cnt_i),
        .fifo_data_o(fifo_data_o), .fifo_valid_o(fifo_valid_o),
        .fifo_ready_i(fifo_ready_i)
    );

    always #5 clk = ~clk;

    int n_asrt = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a3c, ~a[15:0]};
    endfunction

    // Bus slave / FIFO side stimulus knobs, written only by the main process.
    int   ack_pct = 100;
    int   ready_pct = 100;
    int   err_beat = 0;
    bit   rand_cnt = 1'b0;
    int   cnt_fixed = 0;
    int   beat_cnt = 0;
    bit   err_fired = 1'b0;

    always @(negedge clk) begin
        if (rand_cnt)
            fifo_cnt_i = 10'($urandom_range(512, 490));
        else
            fifo_cnt_i = 10'(cnt_fixed);
        fifo_ready_i = ($urandom_range(99) < 32'(ready_pct));
        wbm_dat_i = mem(wbm_adr_o);
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        if (!busy_o && !wbm_cyc_o) begin
            beat_cnt  = 0;
            err_fired = 1'b0;
        end
        if (!rst && wbm_cyc_o) begin
            if (err_beat != 0 && !err_fired && beat_cnt == err_beat - 1) begin
                wbm_err_i = 1'b1;
                err_fired = 1'b1;
            end else if ($urandom_range(99) < 32'(ack_pct)) begin
                wbm_ack_i = 1'b1;
                beat_cnt++;
            end
        end
    end

    // Reference model: a transfer is a queue of bursts of min(blen, rem) words.
    bit          mon_on = 1'b0;
    logic [31:0] m_adr = '0;
    int          m_rem = 0;
    int          m_blen = 0;
    int          m_left = 0;
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    bit          m_err = 1'b0;
    bit          m_go = 1'b0;
    bit          prev_en = 1'b0;
    int          n_writes = 0;
    int          n_dones = 0;
    logic [34:0] beat_log[$];
    bit          exp_cyc;
    logic [2:0]  cti_e;
    int          bs;

    always begin
        @(negedge clk);
        #4;
        if (mon_on) begin
            exp_cyc = (m_left > 0) || m_go;
            if (m_go) begin
                m_left = (m_blen < m_rem) ? m_blen : m_rem;
                m_go = 1'b0;
            end
            cti_e = !exp_cyc ? 3'b000 : (m_left == 1 ? 3'b111 : 3'b010);
            chk("cyc", 64'(wbm_cyc_o), 64'(exp_cyc));
            chk("stb", 64'(wbm_stb_o), 64'(exp_cyc));
            chk("cti", 64'(wbm_cti_o), 64'(cti_e));
            chk("busy", 64'(busy_o), 64'(m_busy));
            chk("done", 64'(done_o), 64'(m_done));
            chk("err", 64'(err_o), 64'(m_err));
            chk("sel", 64'(wbm_sel_o), 64'(4'hF));
            chk("we_bte", 64'({wbm_we_o, wbm_bte_o}), 64'(0));
            chk("fifo_valid", 64'(fifo_valid_o), 64'(wbm_ack_i & exp_cyc));
            if (exp_cyc)
                chk("adr", 64'(wbm_adr_o), 64'(m_adr));
            if (fifo_valid_o)
                chk("fifo_data", 64'(fifo_data_o), 64'(mem(m_adr)));
            if (done_o)
                n_dones++;
            if (rst) begin
                m_left = 0; m_busy = 0; m_done = 0; m_err = 0;
                m_go = 0; prev_en = 0; m_rem = 0;
            end else begin
                m_done = 1'b0;
                if (m_left > 0) begin
                    if (wbm_err_i) begin
                        m_left = 0; m_busy = 0; m_err = 1;
                    end else if (wbm_ack_i) begin
                        if (!fifo_ready_i)
                            m_err = 1'b1;
                        beat_log.push_back({cti_e, m_adr});
                        n_writes++;
                        m_adr = m_adr + 32'd4;
                        m_rem--;
                        m_left--;
                        if (m_left == 0) begin
                            if (m_rem == 0) begin
                                m_busy = 0; m_done = 1;
                            end else if (!enable_i) begin
                                m_busy = 0;
                            end
                        end
                    end
                end else if (m_busy) begin
                    if (!enable_i)
                        m_busy = 1'b0;
                    else if (512 - int'(fifo_cnt_i) >= ((m_blen < m_rem) ? m_blen : m_rem))
                        m_go = 1'b1;
                end else if (enable_i && !prev_en) begin
                    bs = int'(burst_size_i);
                    m_adr  = start_adr_i;
                    m_rem  = int'(buf_size_i);
                    m_blen = (bs == 0) ? 1 : ((bs > 16) ? 16 : bs);
                    m_err  = 1'b0;
                    if (m_rem == 0) m_done = 1'b1;
                    else m_busy = 1'b1;
                end
                prev_en = enable_i;
            end
        end
    end

    task automatic start_xfer(input logic [31:0] a, input int sz, input int b);
        @(negedge clk);
        enable_i = 1'b0;
        start_adr_i = a;
        buf_size_i = 24'(sz);
        burst_size_i = 8'(b);
        @(negedge clk);
        enable_i = 1'b1;
    endtask

    task automatic wait_cyc(input string nm);
        int k = 0;
        do begin
            @(negedge clk); #5; k++;
        end while (!wbm_cyc_o && k < 200);
        chk({nm, "_cyc_timeout"}, 64'(k < 200), 64'(1));
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        do begin
            @(negedge clk); #5; k++;
        end while ((busy_o || wbm_cyc_o || m_busy || m_left > 0) && k < 3000);
        chk({nm, "_idle_timeout"}, 64'(k < 3000), 64'(1));
        repeat (3) @(negedge clk);
    endtask

    task automatic run_xfer(input string nm, input logic [31:0] a, input int sz,
                            input int b, input int exp_w, input int exp_d, input bit drop);
        int w0 = n_writes;
        int d0 = n_dones;
        start_xfer(a, sz, b);
        if (drop) begin
            wait_cyc(nm);
            @(negedge clk);
            enable_i = 1'b0;
        end
        wait_idle(nm);
        chk({nm, "_writes"}, 64'(n_writes - w0), 64'(exp_w));
        chk({nm, "_dones"}, 64'(n_dones - d0), 64'(exp_d));
        enable_i = 1'b0;
        @(negedge clk);
    endtask

    int b0;

    initial begin
        repeat (2) @(negedge clk);
        mon_on = 1'b1;
        repeat (2) @(negedge clk);
        #5;
        chk("rst_cyc", 64'(wbm_cyc_o), 64'(0));
        chk("rst_sel", 64'(wbm_sel_o), 64'(4'hF));
        chk("rst_adr", 64'(wbm_adr_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        b0 = beat_log.size();
        run_xfer("t1", 32'h100, 8, 4, 8, 1, 1'b0);
        chk("t1_b0", 64'(beat_log[b0]), 64'({3'b010, 32'h100}));
        chk("t1_b3", 64'(beat_log[b0+3]), 64'({3'b111, 32'h10C}));
        chk("t1_b4", 64'(beat_log[b0+4]), 64'({3'b010, 32'h110}));
        chk("t1_b7", 64'(beat_log[b0+7]), 64'({3'b111, 32'h11C}));
        chk("t1_busy", 64'(busy_o), 64'(0));

        b0 = beat_log.size();
        run_xfer("t2", 32'h100, 10, 4, 10, 1, 1'b0);
        chk("t2_b8", 64'(beat_log[b0+8]), 64'({3'b010, 32'h120}));
        chk("t2_b9", 64'(beat_log[b0+9]), 64'({3'b111, 32'h124}));

        cnt_fixed = 509;
        start_xfer(32'h200, 4, 4);
        repeat (10) @(negedge clk);
        #5;
        chk("t3_hold", 64'(wbm_cyc_o), 64'(0));
        @(posedge clk); #2;
        cnt_fixed = 508;
        @(negedge clk); #5;
        chk("t3_still_low", 64'(wbm_cyc_o), 64'(0));
        @(negedge clk); #5;
        chk("t3_rise", 64'(wbm_cyc_o), 64'(1));
        wait_idle("t3");
        enable_i = 1'b0;
        cnt_fixed = 0;

        err_beat = 2;
        run_xfer("t4", 32'h300, 8, 4, 1, 0, 1'b0);
        chk("t4_err", 64'(err_o), 64'(1));
        chk("t4_busy", 64'(busy_o), 64'(0));
        err_beat = 0;
        run_xfer("t4b", 32'h340, 4, 4, 4, 1, 1'b0);
        chk("t4b_err_clr", 64'(err_o), 64'(0));

        run_xfer("t5", 32'h400, 16, 4, 4, 0, 1'b1);
        chk("t5_busy", 64'(busy_o), 64'(0));

        run_xfer("t6", 32'h500, 0, 4, 0, 1, 1'b0);
        run_xfer("clamp0", 32'h600, 3, 0, 3, 1, 1'b0);
        run_xfer("wrap", 32'hFFFF_FFF8, 5, 40, 5, 1, 1'b0);

        rand_cnt = 1'b1;
        for (int k = 0; k < 25; k++) begin
            int sz = int'($urandom_range(40));
            ack_pct = int'($urandom_range(100, 40));
            ready_pct = (k % 4 == 0) ? 90 : 100;
            run_xfer("rnd", (k % 5 == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC),
                     sz, int'($urandom_range(20)), sz, 1, 1'b0);
        end
        rand_cnt = 1'b0;
        ack_pct = 100;
        ready_pct = 100;

        start_xfer(32'h700, 16, 4);
        wait_cyc("t7");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        enable_i = 1'b0;
        @(negedge clk); #5;
        chk("t7_cyc", 64'(wbm_cyc_o), 64'(0));
        chk("t7_stb", 64'(wbm_stb_o), 64'(0));
        chk("t7_busy", 64'(busy_o), 64'(0));
        chk("t7_valid", 64'(fifo_valid_o), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #5;
        chk("t7_quiet", 64'({wbm_cyc_o, fifo_valid_o, busy_o}), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stream_writer_ctrl.md
Name: wb_stream_writer_ctrl

Overview:
Wishbone burst-read master that fetches a linear buffer from memory and pushes it into the stream writer FIFO.
Software programs start address, length and burst size, then pulses enable.
The block checks FIFO occupancy and only starts a burst when the FIFO has room for the whole burst, so every beat is accepted without back-pressure.
It reports busy, done and error status to the register front end.

Parameters:
WB_AW, 32, Wishbone address width (byte address)
WB_DW, 32, Wishbone data width; address step per beat = WB_DW/8
FIFO_AW, 9, FIFO depth exponent; depth = 2**FIFO_AW
MAX_BURST, 16, upper clamp for burst length in words
LEN_W, 24, width of buffer length (words)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
enable_i  in  1  start request; rising edge starts a transfer, low level requests abort
start_adr_i  in  WB_AW  buffer base byte address, word aligned
buf_size_i  in  LEN_W  buffer length in words
burst_size_i  in  8  requested burst length in words
busy_o  out  1  transfer in progress
done_o  out  1  one-cycle pulse on successful completion
err_o  out  1  sticky error flag
wbm_adr_o  out  WB_AW  Wishbone address
wbm_sel_o  out  WB_DW/8  byte select; all ones
wbm_we_o  out  1  write enable; constant 0
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_cti_o  out  3  cycle type: 3'b010 incrementing, 3'b111 end of burst
wbm_bte_o  out  2  burst type extension; constant 2'b00 (linear)
wbm_dat_i  in  WB_DW  read data
wbm_ack_i  in  1  acknowledge
wbm_err_i  in  1  bus error
fifo_cnt_i  in  FIFO_AW+1  FIFO occupancy
fifo_data_o  out  WB_DW  FIFO write data
fifo_valid_o  out  1  FIFO write strobe
fifo_ready_i  in  1  FIFO not full

Behaviour:
- Reset values: all outputs 0, except wbm_sel_o, which is all ones. State = IDLE; internal counters = 0.
- Start event: enable_i & ~enable_q, where enable_q is enable_i registered.
- On start, latch the configuration:
  - adr = start_adr_i
  - rem = buf_size_i
  - blen_cfg = clamp(burst_size_i, 1..MAX_BURST); a value of 0 is treated as 1
  - err_o cleared
- IDLE:
  - On start with buf_size_i == 0: pulse done_o in the next cycle and stay in IDLE.
  - Otherwise go to WAIT_SPACE and set busy_o = 1.
- WAIT_SPACE:
  - len = min(blen_cfg, rem).
  - If enable_i == 0: return to IDLE, busy_o = 0, no done_o.
  - Else if (2**FIFO_AW - fifo_cnt_i) >= len: go to BURST, registering cyc = stb = 1 and beat counter = len on that edge.
  - Otherwise wait; cyc stays low.
- BURST:
  - wbm_adr_o = adr.
  - wbm_cti_o = 3'b111 when the beat counter == 1, else 3'b010.
  - On each ack: adr += WB_DW/8, beat counter decrements, rem decrements.
  - On the ack with beat counter == 1: cyc and stb go low on that edge, then:
    - rem becomes 0 → DONE
    - enable_i == 0 → IDLE, with no done_o
    - otherwise → WAIT_SPACE
- DONE: pulse done_o for one cycle, set busy_o = 0, go to IDLE.
- FIFO path (combinational):
  - fifo_data_o = wbm_dat_i
  - fifo_valid_o = wbm_ack_i & wbm_cyc_o & wbm_stb_o
- Ack while fifo_ready_i == 0 (space check violated): set err_o; the data is dropped and the transfer continues.
- wbm_err_i during BURST: cyc and stb go low on that edge, err_o is set, go to IDLE, busy_o = 0, no done_o.
- An ack and an err in the same cycle: err wins and no beat is counted.
- A start event while busy is ignored.
- Reset mid-burst: cyc and stb are low after the reset edge and no further FIFO writes occur.
- The address wraps modulo 2**WB_AW.
- rem arithmetic is LEN_W bits wide and never underflows, because len <= rem.

Test Plan:
1. start_adr=0x100, buf=8, burst=4, fifo_cnt=0, ack every cycle → two bursts: adr 0x100–0x10C with cti 010,010,010,111, then adr 0x110–0x11C with the same pattern; 8 FIFO writes; done_o high for exactly 1 cycle; busy_o low afterwards.
2. buf=10, burst=4 → bursts of 4, 4 and 2 beats; the third burst has cti 010,111 at 0x120–0x124; 10 FIFO writes.
3. FIFO_AW=9, fifo_cnt_i=509, burst=4 → cyc stays low; after fifo_cnt_i drops to 508, cyc rises on the next edge.
4. wbm_err_i on beat 2 of 4 → cyc low on the following cycle; err_o=1; busy_o=0; no done_o; exactly 1 FIFO write. The next start clears err_o.
5. enable_i dropped during beat 1 of a 4-beat burst with buf=16 → the burst completes (4 writes), no further cyc, no done_o, busy_o=0.
6. buf=0 start → done_o pulse and no cyc. Reset asserted mid-burst → cyc, stb, busy_o and fifo_valid_o are 0 after the edge.
